// File: rtl/nios2_freertos_key_in.sv
// nios2_freertos_key_in: synchronised PIO input port with edge capture, IRQ mask and Avalon-MM readback
module nios2_freertos_key_in #(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = 1,
    parameter int RESET_LEVEL = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam logic [WIDTH-1:0] IDLE = (RESET_LEVEL != 0) ? '1 : '0;

    logic [WIDTH-1:0] s1_q, s2_q, d3_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] edge_det, clr;
    logic             wr;
    logic             unused_writedata;

    assign unused_writedata = ^writedata;

    // edge select on the synchronised stream, then write decode and capture/mask next state
    always_comb begin
        edge_det = (EDGE_TYPE == 0) ? (s2_q & ~d3_q) :
                   (EDGE_TYPE == 1) ? (~s2_q & d3_q) : (s2_q ^ d3_q);
        wr       = chipselect & ~write_n;
        clr      = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        cap_d    = (cap_q & ~clr) | edge_det;
        mask_d   = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    end

    // synchroniser, delay flop and control registers; reset overrides writes and captures
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q   <= IDLE;
            s2_q   <= IDLE;
            d3_q   <= IDLE;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            s1_q   <= in_port;
            s2_q   <= s1_q;
            d3_q   <= s2_q;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    // zero-latency readback, zero-extended above WIDTH
    always_comb begin
        readdata              = '0;
        readdata[WIDTH-1:0]   = (address == 2'd0) ? s2_q :
                                (address == 2'd2) ? mask_q :
                                (address == 2'd3) ? cap_q : '0;
    end

    assign irq = |(cap_q & mask_q);
endmodule

// File: tb/tb_nios2_freertos_key_in.sv
// tb_nios2_freertos_key_in: rising/falling/any instances checked against a sample-history model
module tb_nios2_freertos_key_in;
    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd [3];
    logic        irq_o [3];

    int checks = 0;
    int errors = 0;

    logic [3:0] hist [$];
    logic [3:0] mmask;
    logic [3:0] mcap [3];

    nios2_freertos_key_in #(.WIDTH(4), .EDGE_TYPE(0), .RESET_LEVEL(1)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[0]), .irq(irq_o[0]));
    nios2_freertos_key_in #(.WIDTH(4), .EDGE_TYPE(1), .RESET_LEVEL(1)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[1]), .irq(irq_o[1]));
    nios2_freertos_key_in #(.WIDTH(4), .EDGE_TYPE(2), .RESET_LEVEL(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[2]), .irq(irq_o[2]));

    initial clk = 0;
    always #5 clk = ~clk;

    // hist[0] = in_port seen at the last edge, hist[1] = two edges ago (the visible data), hist[2] = three ago
    task automatic do_tick();
        logic [3:0] now_v, old_v, rose, fell, clr;
        @(posedge clk);
        if (!reset_n) begin
            hist = '{4'hF, 4'hF, 4'hF};
            mmask = 4'h0;
            for (int t = 0; t < 3; t++) mcap[t] = 4'h0;
        end else begin
            now_v = hist[1];
            old_v = hist[2];
            rose = now_v & ~old_v;
            fell = old_v & ~now_v;
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
            mcap[0] = (mcap[0] & ~clr) | rose;
            mcap[1] = (mcap[1] & ~clr) | fell;
            mcap[2] = (mcap[2] & ~clr) | rose | fell;
            if (chipselect && !write_n && address == 2'd2) mmask = writedata[3:0];
            hist.push_front(in_port);
            void'(hist.pop_back());
        end
        #1;
    endtask

    function automatic logic [31:0] mexp(int a, int t);
        case (a)
            0: return {28'h0, hist[1]};
            2: return {28'h0, mmask};
            3: return {28'h0, mcap[t]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic mirq(int t);
        return |(mcap[t] & mmask);
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1;
        write_n = 0;
        do_tick();
        chipselect = 0;
        write_n = 1;
        writedata = $urandom;
    endtask

    task automatic test_reset();
        reset_n = 0; in_port = 4'hF; chipselect = 0; write_n = 1; address = 0; writedata = 0;
        hist = '{4'hF, 4'hF, 4'hF};
        do_tick();
        do_tick();
        reset_n = 1;
        for (int c = 0; c < 10; c++) begin
            do_tick();
            for (int a = 0; a < 4; a++) begin
                address = 2'(a);
                #1;
                for (int t = 0; t < 3; t++) begin
                    checks++;
                    if (rd[t] !== mexp(a, t)) begin errors++; $display("FAIL reset rd inst%0d addr%0d got %h want %h", t, a, rd[t], mexp(a, t)); end
                end
            end
            for (int t = 0; t < 3; t++) begin
                checks++;
                if (irq_o[t] !== 1'b0) begin errors++; $display("FAIL reset irq inst%0d got %b want 0", t, irq_o[t]); end
            end
        end
        address = 0; #1;
        checks++;
        if (rd[1] !== 32'hF) begin errors++; $display("FAIL reset data got %h want 0000000f", rd[1]); end
    endtask

    task automatic test_fall_irq();
        wr(2'd2, 32'h1);
        in_port = 4'hE;
        for (int c = 0; c < 3; c++) begin
            do_tick();
            for (int a = 0; a < 4; a++) begin
                address = 2'(a);
                #1;
                for (int t = 0; t < 3; t++) begin
                    checks++;
                    if (rd[t] !== mexp(a, t)) begin errors++; $display("FAIL fall_irq rd inst%0d addr%0d got %h want %h", t, a, rd[t], mexp(a, t)); end
                end
            end
            for (int t = 0; t < 3; t++) begin
                checks++;
                if (irq_o[t] !== mirq(t)) begin errors++; $display("FAIL fall_irq irq inst%0d got %b want %b", t, irq_o[t], mirq(t)); end
            end
        end
        address = 3; #1;
        checks++;
        if (rd[1] !== 32'h1 || irq_o[1] !== 1'b1) begin errors++; $display("FAIL fall_irq latency cap %h irq %b want 1/1", rd[1], irq_o[1]); end
    endtask

    task automatic test_clear();
        wr(2'd3, 32'h0);
        address = 3; #1;
        checks++;
        if (rd[1] !== 32'h1 || irq_o[1] !== 1'b1) begin errors++; $display("FAIL clear_zero cap %h irq %b want 1/1", rd[1], irq_o[1]); end
        wr(2'd3, 32'h1);
        address = 3; #1;
        checks++;
        if (rd[1] !== 32'h0 || irq_o[1] !== 1'b0) begin errors++; $display("FAIL clear_one cap %h irq %b want 0/0", rd[1], irq_o[1]); end
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (rd[t] !== mexp(3, t) || irq_o[t] !== mirq(t)) begin errors++; $display("FAIL clear model inst%0d cap %h irq %b want %h/%b", t, rd[t], irq_o[t], mexp(3, t), mirq(t)); end
        end
    endtask

    task automatic test_masked();
        wr(2'd2, 32'h0);
        in_port = 4'hA;
        for (int c = 0; c < 3; c++) begin
            do_tick();
            address = 3; #1;
            for (int t = 0; t < 3; t++) begin
                checks++;
                if (rd[t] !== mexp(3, t) || irq_o[t] !== mirq(t)) begin errors++; $display("FAIL masked inst%0d cap %h irq %b want %h/%b", t, rd[t], irq_o[t], mexp(3, t), mirq(t)); end
            end
        end
        checks++;
        if (rd[1] !== 32'h4 || irq_o[1] !== 1'b0) begin errors++; $display("FAIL masked capture cap %h irq %b want 4/0", rd[1], irq_o[1]); end
        wr(2'd2, 32'h4);
        checks++;
        if (irq_o[1] !== 1'b1) begin errors++; $display("FAIL unmask irq got %b want 1", irq_o[1]); end
        wr(2'd3, 32'hF);
    endtask

    task automatic test_collision();
        in_port = 4'h8;
        do_tick();
        do_tick();
        wr(2'd3, 32'h2);
        address = 3; #1;
        checks++;
        if (rd[1][1] !== 1'b1) begin errors++; $display("FAIL collision cap %h want bit1 set", rd[1]); end
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (rd[t] !== mexp(3, t)) begin errors++; $display("FAIL collision model inst%0d cap %h want %h", t, rd[t], mexp(3, t)); end
        end
    endtask

    task automatic test_any();
        logic [3:0] seq = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            wr(2'd3, 32'hF);
            in_port[3] = seq[k];
            for (int c = 0; c < 4; c++) begin
                do_tick();
                for (int a = 0; a < 4; a++) begin
                    address = 2'(a);
                    #1;
                    for (int t = 0; t < 3; t++) begin
                        checks++;
                        if (rd[t] !== mexp(a, t)) begin errors++; $display("FAIL any rd inst%0d addr%0d got %h want %h", t, a, rd[t], mexp(a, t)); end
                    end
                end
            end
            address = 3; #1;
            checks++;
            if (rd[2][3] !== 1'b1 || rd[2][31:4] !== 28'h0) begin errors++; $display("FAIL any toggle%0d cap %h want bit3 set", k, rd[2]); end
            address = 1; #1;
            checks++;
            if (rd[2] !== 32'h0) begin errors++; $display("FAIL reserved got %h want 0", rd[2]); end
        end
    endtask

    task automatic test_reset_mid();
        in_port = 4'hF;
        repeat (4) do_tick();
        in_port = 4'h0;
        repeat (4) do_tick();
        address = 3; #1;
        checks++;
        if (rd[1] !== 32'hF) begin errors++; $display("FAIL pre_reset cap %h want f", rd[1]); end
        reset_n = 0;
        address = 2; writedata = 32'hF; chipselect = 1; write_n = 0;
        do_tick();
        reset_n = 1; chipselect = 0; write_n = 1;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            for (int t = 0; t < 3; t++) begin
                checks++;
                if (rd[t] !== mexp(a, t)) begin errors++; $display("FAIL reset_mid rd inst%0d addr%0d got %h want %h", t, a, rd[t], mexp(a, t)); end
            end
        end
        address = 3; #1;
        checks++;
        if (rd[1] !== 32'h0 || irq_o[1] !== 1'b0) begin errors++; $display("FAIL reset_mid cap %h irq %b want 0/0", rd[1], irq_o[1]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) in_port = 4'($urandom);
            reset_n = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0) begin
                address = 2'($urandom);
                writedata = $urandom;
                chipselect = 1;
                write_n = 0;
            end else begin
                chipselect = 1'($urandom);
                write_n = 1;
            end
            do_tick();
            reset_n = 1; chipselect = 0; write_n = 1;
            for (int a = 0; a < 4; a++) begin
                address = 2'(a);
                #1;
                for (int t = 0; t < 3; t++) begin
                    checks++;
                    if (rd[t] !== mexp(a, t)) begin errors++; $display("FAIL random c%0d rd inst%0d addr%0d got %h want %h", c, t, a, rd[t], mexp(a, t)); end
                end
            end
            for (int t = 0; t < 3; t++) begin
                checks++;
                if (irq_o[t] !== mirq(t)) begin errors++; $display("FAIL random c%0d irq inst%0d got %b want %b", c, t, irq_o[t], mirq(t)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fall_irq();
        test_clear();
        test_masked();
        test_collision();
        test_any();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nios2_freertos_key_in.md
NIOS2_FREERTOS_KEY_IN -- requirements
Module: nios2_freertos_key_in

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of input bits (1..32).
REQ-002 The block SHALL have parameter EDGE_TYPE, default 1, selecting edge detection: 0 = rising, 1 = falling, 2 = any.
REQ-003 The block SHALL have parameter RESET_LEVEL, default 1, giving the idle level loaded into the synchroniser and delay flops at reset (1 or 0, replicated to WIDTH bits).
REQ-004 The block SHALL use one clock; reset is synchronous and active-low, with ports named clk and reset_n.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all flops update on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-007 The block SHALL have port address, input, 2 bits: Avalon-MM slave register select.
REQ-008 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-009 The block SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-010 The block SHALL have port writedata, input, 32 bits: write data.
REQ-011 The block SHALL have port in_port, input, WIDTH bits: asynchronous external inputs (push-buttons/switches).
REQ-012 The block SHALL have port readdata, output, 32 bits: read data, zero-extended above WIDTH.
REQ-013 The block SHALL have port irq, output, 1 bit: active-high level interrupt request to the processor.

Function
REQ-014 in_port SHALL pass through a 2-flop synchroniser (s1, s2) followed by a delay flop d3; no other logic SHALL observe in_port directly.
REQ-015 The edge-detect vector SHALL be s2 & ~d3 for EDGE_TYPE 0, ~s2 & d3 for EDGE_TYPE 1, and s2 ^ d3 for EDGE_TYPE 2.
REQ-016 The register map SHALL be: address 0 = data (RO, returns s2); address 1 = reserved (reads 0, writes ignored); address 2 = irq_mask (RW, WIDTH bits); address 3 = edge_capture (read; write-1-to-clear per bit).
REQ-017 A write SHALL occur on a clock edge where chipselect=1 and write_n=0; only writedata[WIDTH-1:0] SHALL be used.
REQ-018 Writes to address 0 or 1 SHALL have no effect.
REQ-019 readdata SHALL be combinational from address and the current register values (zero read latency), independent of chipselect; bits above WIDTH SHALL be 0.
REQ-020 Latency: an in_port change present at clock edge N SHALL appear in s2 after edge N+1, set edge_capture after edge N+2, and raise irq in the cycle following edge N+2 (if masked in).
REQ-021 edge_capture[i] SHALL be set on any edge where edge-detect[i]=1, and SHALL hold until cleared by a write of 1 to bit i at address 3; writing 0 SHALL leave the bit unchanged.
REQ-022 When edge-detect[i]=1 and a write-1-to-clear of bit i occur on the same edge, the bit SHALL be set (set wins).
REQ-023 irq SHALL be combinational |(edge_capture & irq_mask); changing irq_mask SHALL affect irq in the cycle following the write edge, without altering edge_capture.
REQ-024 Edges SHALL be captured regardless of irq_mask state.
REQ-025 A pulse on in_port shorter than one clk period MAY be missed; a level held for 2 or more clk periods SHALL be captured exactly once per qualifying edge.

Reset
REQ-026 When reset_n=0 at a clock edge, s1, s2 and d3 SHALL load {WIDTH{RESET_LEVEL}}, and irq_mask and edge_capture SHALL load 0.
REQ-027 Consequently irq SHALL be 0, and readdata SHALL read 0 at addresses 1, 2 and 3, starting in the cycle after the reset edge.
REQ-028 Reset SHALL take priority over any simultaneous write or edge detection.
REQ-029 No edge SHALL be captured during reset; if in_port equals RESET_LEVEL after reset, no spurious edge SHALL be captured.
REQ-030 Reset asserted mid-operation SHALL discard any pending captured edges.

Verification
REQ-031 Scenario (WIDTH=4, EDGE_TYPE=1): reset, in_port=4'hF, write mask 4'h1 to addr 2, drop in_port[0] to 0 at edge N -> edge_capture reads 4'h1 after edge N+2, and irq=1 from that cycle.
REQ-032 Scenario (clear): with edge_capture=4'h1, write 4'h1 to addr 3 -> edge_capture reads 0 and irq=0 in the next cycle; writing 4'h0 instead -> edge_capture stays 4'h1.
REQ-033 Scenario (masked): mask=0, falling edge on in_port[2] -> edge_capture reads 4'h4 and irq stays 0; then write mask 4'h4 -> irq=1 in the next cycle.
REQ-034 Scenario (collision): clear of bit 1 written on the same edge bit 1's edge-detect is high -> edge_capture[1] remains 1.
REQ-035 Scenario (reset state): release reset with in_port=4'hF -> addr 0 reads 4'hF, addr 3 reads 0, and irq stays 0 for 10 cycles; reset_n=0 while edge_capture=4'hF -> edge_capture reads 0 after the reset edge.
REQ-036 Scenario (EDGE_TYPE=2 and readback): toggle in_port[3] 0->1->0 with 4-cycle spacing -> edge_capture[3] is set after each edge; addr 1 always reads 32'h0; upper bits of readdata always read 0.
